cmd_host: RTL and testbench

On-chip host model for the serial command parser: it issues one parser command (command byte, optional 16-bit length, optional '0'/'1' payload) on the parser's receive-byte interface and collects the ASCII '0'/'1' response on the parser's transmit-byte interface. Toward the parser's transmit side it behaves as the UART transmitter, driving the `tx_ready` handshake. It is used for FPGA self-test and loopback benches in place of the UART PHY and PC host.

---
 rtl/cmd_host_if.sv | 19 +
 rtl/cmd_host.sv | 199 +++++++++++++++++++
 tb/tb_cmd_host.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_host_if.sv
// Byte-level link between the host model and the command parser.
// Signal suffixes are from the host's point of view: master is the host, slave is the parser.
interface cmd_host_if;
    logic [7:0] rx_data_o;
    logic       new_rx_data_o;
    logic       tx_start_i;
    logic [7:0] tx_data_i;
    logic       tx_ready_o;

    modport master (
        output rx_data_o, new_rx_data_o, tx_ready_o,
        input  tx_start_i, tx_data_i
    );

    modport slave (
        input  rx_data_o, new_rx_data_o, tx_ready_o,
        output tx_start_i, tx_data_i
    );
endinterface

// File: rtl/cmd_host.sv
// Host model for the serial command parser: sends one command, length and payload byte stream,
// and collects the ASCII '0'/'1' response while acting as the parser's UART transmitter sink.
module cmd_host #(
    parameter int MAX_BITS       = 32,
    parameter int GAP_CYCLES     = 4,
    parameter int TX_BUSY_CYCLES = 3,
    parameter int TIMEOUT        = 65535
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start_i,
    input  logic [7:0]          cmd_i,
    input  logic [15:0]         nbits_i,
    input  logic [MAX_BITS-1:0] wdata_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [MAX_BITS-1:0] rdata_o,
    cmd_host_if.master          bus
);

    localparam int GW  = $clog2(GAP_CYCLES);
    localparam int TXW = $clog2(TX_BUSY_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT + 1);
    localparam int IW  = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_CMD, S_LEN_HI, S_LEN_LO, S_PAY, S_RECV, S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [15:0]         nbits_q, nbits_d;
    logic [MAX_BITS-1:0] wdata_q, wdata_d;
    logic [MAX_BITS-1:0] rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [7:0]          rx_data_q, rx_data_d;
    logic                new_rx_q, new_rx_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [15:0]         idx_q, idx_d;
    logic [TOW-1:0]      to_q, to_d;
    logic [TXW-1:0]      txc_q, txc_d;

    logic tx_ready, accept, gap_end, in_send;

    function automatic logic is_len(input logic [7:0] c);
        return c inside {"s", "i", "g", "o", "e"};
    endfunction

    function automatic logic is_pay(input logic [7:0] c);
        return c inside {"s", "i"};
    endfunction

    function automatic logic is_resp(input logic [7:0] c);
        return c inside {"g", "o"};
    endfunction

    // Payload bits beyond the stored vector are sent as '0'.
    function automatic logic [7:0] pay_char(input logic [MAX_BITS-1:0] w, input logic [15:0] k);
        if (32'(k) < MAX_BITS && w[k[IW-1:0]]) return 8'h31;
        return 8'h30;
    endfunction

    assign tx_ready = (txc_q == '0);
    assign accept   = bus.tx_start_i && tx_ready;
    assign gap_end  = (gap_q == GW'(GAP_CYCLES - 1));
    assign in_send  = state_q inside {S_SEND_CMD, S_LEN_HI, S_LEN_LO, S_PAY};

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            nbits_q   <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            rx_data_q <= '0;
            new_rx_q  <= 1'b0;
            gap_q     <= '0;
            idx_q     <= '0;
            to_q      <= '0;
            txc_q     <= '0;
        end else begin
            // NOTE: non-blocking updates make every flop sample pre-edge values, independent of statement order.
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            nbits_q   <= nbits_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            rx_data_q <= rx_data_d;
            new_rx_q  <= new_rx_d;
            gap_q     <= gap_d;
            idx_q     <= idx_d;
            to_q      <= to_d;
            txc_q     <= txc_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        // NOTE: every _d takes a default first, so no branch below can leave one unassigned and infer a latch.
        state_d   = state_q;
        cmd_d     = cmd_q;
        nbits_d   = nbits_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        rx_data_d = rx_data_q;
        new_rx_d  = 1'b0;
        gap_d     = (in_send && !gap_end) ? gap_q + GW'(1) : '0;
        idx_d     = idx_q;
        to_d      = to_q;
        txc_d     = accept ? TXW'(TX_BUSY_CYCLES) : (tx_ready ? txc_q : txc_q - TXW'(1));

        unique case (state_q)
            S_IDLE: if (start_i) begin
                cmd_d     = cmd_i;
                nbits_d   = nbits_i;
                wdata_d   = wdata_i;
                rdata_d   = '0;
                err_d     = 1'b0;
                rx_data_d = cmd_i;
                new_rx_d  = 1'b1;
                state_d   = S_SEND_CMD;
            end
            S_SEND_CMD: if (gap_end) begin
                if (is_len(cmd_q)) begin
                    rx_data_d = nbits_q[15:8];
                    new_rx_d  = 1'b1;
                    state_d   = S_LEN_HI;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_LEN_HI: if (gap_end) begin
                rx_data_d = nbits_q[7:0];
                new_rx_d  = 1'b1;
                state_d   = S_LEN_LO;
            end
            S_LEN_LO: if (gap_end) begin
                if (cmd_q == "e" || nbits_q == 16'd0) begin
                    state_d = S_DONE;
                end else if (is_pay(cmd_q)) begin
                    rx_data_d = pay_char(wdata_q, 16'd0);
                    new_rx_d  = 1'b1;
                    idx_d     = 16'd1;
                    state_d   = S_PAY;
                end else if (is_resp(cmd_q)) begin
                    idx_d   = '0;
                    to_d    = '0;
                    state_d = S_RECV;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_PAY: if (gap_end) begin
                if (idx_q == nbits_q) begin
                    state_d = S_DONE;
                end else begin
                    rx_data_d = pay_char(wdata_q, idx_q);
                    new_rx_d  = 1'b1;
                    idx_d     = idx_q + 16'd1;
                end
            end
            S_RECV: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (accept) begin
                    if (32'(idx_q) < MAX_BITS) rdata_d[idx_q[IW-1:0]] = (bus.tx_data_i == 8'h31);
                    if (!(bus.tx_data_i inside {8'h30, 8'h31})) err_d = 1'b1;
                    idx_d = idx_q + 16'd1;
                    to_d  = '0;
                    if (idx_q + 16'd1 == nbits_q) state_d = S_DONE;
                end else if (to_q == TOW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    to_d = to_q + TOW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy_o = !(state_q inside {S_IDLE, S_DONE});
        done_o = (state_q == S_DONE);
    end

    assign err_o             = err_q;
    assign rdata_o           = rdata_q;
    assign bus.rx_data_o     = rx_data_q;
    assign bus.new_rx_data_o = new_rx_q;
    assign bus.tx_ready_o    = tx_ready;

endmodule

// File: tb/tb_cmd_host.sv
// Self-checking bench for cmd_host: a scoreboard of expected parser-bound bytes plus a small
// parser model answering over the transmit handshake.
module tb_cmd_host;

    localparam int MAX_BITS = 32;
    localparam int GAP      = 4;
    localparam int TXB      = 3;
    localparam int TO       = 16;

    logic                clk     = 1'b0;
    logic                rstn    = 1'b0;
    logic                start_i = 1'b0;
    logic [7:0]          cmd_i   = '0;
    logic [15:0]         nbits_i = '0;
    logic [MAX_BITS-1:0] wdata_i = '0;
    logic                busy_o, done_o, err_o;
    logic [MAX_BITS-1:0] rdata_o;

    cmd_host_if ifc ();

    cmd_host #(
        .MAX_BITS(MAX_BITS), .GAP_CYCLES(GAP), .TX_BUSY_CYCLES(TXB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .cmd_i(cmd_i), .nbits_i(nbits_i),
        .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .rdata_o(rdata_o), .bus(ifc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] data;
        int         at;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] resp_buf [64];
    int         resp_len;

    // Scoreboard: every byte pulse must match the oldest expected byte and its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifc.new_rx_data_o === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rx_pulse: got byte %h at cycle %0d, required no pulse", ifc.rx_data_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (ifc.rx_data_o !== e.data || cyc != e.at) begin
                        n_err++;
                        $display("FAIL rx_pulse: got byte %h at cycle %0d, required %h at cycle %0d",
                                 ifc.rx_data_o, cyc, e.data, e.at);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Launch a command and push the byte stream the host must emit.
    task automatic launch(input logic [7:0] c, input logic [15:0] n, input logic [MAX_BITS-1:0] w,
                          output int t_l, output int t_end);
        exp_t e;
        int   np, nn;
        logic bitv;
        nn = int'(n);
        @(negedge clk);
        start_i = 1'b1;
        cmd_i   = c;
        nbits_i = n;
        wdata_i = w;
        t_l     = cyc + 1;
        e.data = c; e.at = t_l; exp_q.push_back(e);
        np = 1;
        if (c inside {"s", "i", "g", "o", "e"}) begin
            e.data = n[15:8]; e.at = t_l + GAP;     exp_q.push_back(e);
            e.data = n[7:0];  e.at = t_l + 2 * GAP; exp_q.push_back(e);
            np = 3;
        end
        if (c inside {"s", "i"}) begin
            for (int k = 0; k < nn; k++) begin
                bitv = 1'b0;
                if (k < MAX_BITS) bitv = w[k];
                e.data = bitv ? 8'h31 : 8'h30;
                e.at   = t_l + (3 + k) * GAP;
                exp_q.push_back(e);
                np++;
            end
        end
        t_end = t_l + np * GAP;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen, output int t);
        seen = 1'b0;
        t    = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                seen = 1'b1;
                t    = cyc;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy_o, done_o, err_o, ifc.new_rx_data_o, ifc.tx_ready_o} !== 5'b00001) begin
            n_err++;
            $display("FAIL reset_flags: got %b, required 00001",
                     {busy_o, done_o, err_o, ifc.new_rx_data_o, ifc.tx_ready_o});
        end
        n_cmp++;
        if (rdata_o !== '0 || ifc.rx_data_o !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data: got rdata %h rx_data %h, required 0 and 00", rdata_o, ifc.rx_data_o);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy_o, done_o, err_o, ifc.new_rx_data_o, ifc.tx_ready_o} !== 5'b00001) begin
            n_err++;
            $display("FAIL post_reset_idle: got %b, required 00001",
                     {busy_o, done_o, err_o, ifc.new_rx_data_o, ifc.tx_ready_o});
        end
    endtask

    // Commands that never enter the receive phase.
    task automatic test_send_only();
        logic [7:0]          tc [5] = '{"r", "s", "e", "g", "i"};
        logic [15:0]         tn [5] = '{16'd0, 16'd3, 16'd5, 16'd0, 16'd34};
        logic [MAX_BITS-1:0] tw [5] = '{32'h0, 32'h5, 32'h0, 32'h0, 32'hFFFF_FFFF};
        int t_l, t_end, t;
        bit seen;
        for (int i = 0; i < 5; i++) begin
            launch(tc[i], tn[i], tw[i], t_l, t_end);
            n_cmp++;
            if (busy_o !== 1'b1) begin
                n_err++;
                $display("FAIL busy_after_launch[%0d]: got %b, required 1", i, busy_o);
            end
            wait_done(t_end - cyc + 8, seen, t);
            n_cmp++;
            if (!seen || t != t_end) begin
                n_err++;
                $display("FAIL done_time[%0d]: got cycle %0d, required %0d", i, t, t_end);
            end
            n_cmp++;
            if (busy_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== '0) begin
                n_err++;
                $display("FAIL done_state[%0d]: got busy %b err %b rdata %h, required 0 0 0",
                         i, busy_o, err_o, rdata_o);
            end
            n_cmp++;
            if (exp_q.size() != 0) begin
                n_err++;
                $display("FAIL missing_pulses[%0d]: got %0d bytes outstanding, required 0", i, exp_q.size());
            end
        end
    endtask

    // Parser model answers resp_buf[0..resp_len-1]; a stray request while busy must be ignored.
    task automatic run_resp(input logic [7:0] c, input logic [15:0] n);
        logic [MAX_BITS-1:0] exp_rd;
        logic                exp_err;
        logic [3:0]          pat;
        int                  t_l, t_end;
        bit                  rdy;
        exp_rd  = '0;
        exp_err = 1'b0;
        for (int i = 0; i < resp_len; i++) begin
            if (i < MAX_BITS) exp_rd[i] = (resp_buf[i] == 8'h31);
            if (resp_buf[i] != 8'h30 && resp_buf[i] != 8'h31) exp_err = 1'b1;
        end
        launch(c, n, '0, t_l, t_end);
        while (cyc < t_l + 3 * GAP) @(negedge clk);
        for (int i = 0; i < resp_len; i++) begin
            rdy = 1'b0;
            for (int k = 0; k < 20 && !rdy; k++) begin
                if (ifc.tx_ready_o === 1'b1) rdy = 1'b1;
                else @(negedge clk);
            end
            n_cmp++;
            if (!rdy) begin
                n_err++;
                $display("FAIL tx_ready_wait[%0d]: got tx_ready 0 for 20 cycles, required 1", i);
            end
            ifc.tx_start_i = 1'b1;
            ifc.tx_data_i  = resp_buf[i];
            @(negedge clk);
            ifc.tx_start_i = 1'b0;
            pat[0] = ifc.tx_ready_o;
            n_cmp++;
            if (i == resp_len - 1) begin
                if (done_o !== 1'b1 || rdata_o !== exp_rd || err_o !== exp_err) begin
                    n_err++;
                    $display("FAIL resp_result: got done %b rdata %h err %b, required 1 %h %b",
                             done_o, rdata_o, err_o, exp_rd, exp_err);
                end
            end else if (done_o !== 1'b0) begin
                n_err++;
                $display("FAIL early_done[%0d]: got done 1, required 0", i);
            end
            ifc.tx_start_i = 1'b1;
            ifc.tx_data_i  = "x";
            @(negedge clk);
            ifc.tx_start_i = 1'b0;
            pat[1] = ifc.tx_ready_o;
            @(negedge clk);
            pat[2] = ifc.tx_ready_o;
            @(negedge clk);
            pat[3] = ifc.tx_ready_o;
            n_cmp++;
            if (pat !== 4'b1000) begin
                n_err++;
                $display("FAIL tx_ready_window[%0d]: got %b, required 1000", i, pat);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL resp_pulses: got %0d bytes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_response();
        resp_len = 4;
        resp_buf[0] = "1"; resp_buf[1] = "0"; resp_buf[2] = "0"; resp_buf[3] = "1";
        run_resp("g", 16'd4);
        resp_len = 2;
        resp_buf[0] = "x"; resp_buf[1] = "1";
        run_resp("o", 16'd2);
        // Longer than the response vector: bytes past MAX_BITS are counted but not stored.
        resp_len = 34;
        for (int i = 0; i < 34; i++) resp_buf[i] = "1";
        run_resp("g", 16'd34);
    endtask

    task automatic test_timeout();
        int t_l, t_end, t;
        bit seen;
        @(negedge clk);
        ifc.tx_start_i = 1'b1;
        ifc.tx_data_i  = "B";
        @(negedge clk);
        ifc.tx_start_i = 1'b0;
        n_cmp++;
        if (ifc.tx_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL banner_accept: got tx_ready %b, required 0", ifc.tx_ready_o);
        end
        repeat (4) @(negedge clk);
        launch("o", 16'd2, '0, t_l, t_end);
        wait_done(3 * GAP + TO + 10, seen, t);
        n_cmp++;
        if (!seen || t != t_l + 3 * GAP + TO) begin
            n_err++;
            $display("FAIL timeout_done: got cycle %0d, required %0d", t, t_l + 3 * GAP + TO);
        end
        n_cmp++;
        if (err_o !== 1'b1 || rdata_o !== '0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_result: got err %b rdata %h busy %b, required 1 0 0", err_o, rdata_o, busy_o);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL timeout_pulses: got %0d bytes outstanding, required 0", exp_q.size());
        end
    endtask

    // Second launch mid-command is ignored; reset after the second byte abandons the rest.
    task automatic test_abort();
        int t_l, t_end;
        bit seen;
        launch("s", 16'd3, 32'h5, t_l, t_end);
        @(negedge clk);
        start_i = 1'b1;
        cmd_i   = "r";
        nbits_i = 16'd0;
        @(negedge clk);
        start_i = 1'b0;
        while (cyc < t_l + GAP + 1) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 4) begin
            n_err++;
            $display("FAIL abort_progress: got %0d bytes outstanding, required 4", exp_q.size());
        end
        rstn = 1'b0;
        exp_q.delete();
        #1;
        n_cmp++;
        if ({busy_o, done_o, err_o, ifc.new_rx_data_o, ifc.tx_ready_o, ifc.rx_data_o} !== {5'b00001, 8'h00}
            || rdata_o !== '0) begin
            n_err++;
            $display("FAIL abort_reset: got %b rx %h rdata %h, required 00001 00 0",
                     {busy_o, done_o, err_o, ifc.new_rx_data_o, ifc.tx_ready_o}, ifc.rx_data_o, rdata_o);
        end
        @(negedge clk);
        rstn = 1'b1;
        seen = 1'b0;
        repeat (8 * GAP) begin
            @(negedge clk);
            if (done_o === 1'b1 || busy_o === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL abort_quiet: got done or busy after reset, required both 0");
        end
    endtask

    initial begin
        ifc.tx_start_i = 1'b0;
        ifc.tx_data_i  = 8'h00;
        test_reset();
        test_send_only();
        test_response();
        test_timeout();
        test_abort();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
